cursor_ctrl: RTL and testbench
==============================

Name: cursor_ctrl

Overview:
- Consumes the five debounced button levels (left, center, right, up, down) and drives the player's targeting cursor on the Battleship grid.
- Synchronizes the levels and detects press edges.
- Moves the cursor one cell per press, with auto-repeat while a direction is held.
- Issues a fire request with a valid/ready handshake to the game-logic stage.
- Sits between the button debouncer and the game FSM / VGA cursor overlay.

Parameters:
GRID_W, 10, grid columns; cursor x range 0..GRID_W-1
GRID_H, 10, grid rows; cursor y range 0..GRID_H-1
XW, 4, width of x outputs; must be >= clog2(GRID_W)
YW, 4, width of y outputs; must be >= clog2(GRID_H)
REPEAT_DELAY, 50000000, clk cycles a direction must be held before the first auto-repeat step (>= 2)
REPEAT_RATE, 10000000, clk cycles between subsequent auto-repeat steps (>= 2)
WRAP, 0, 0 = clamp at grid edges; 1 = wrap to the opposite edge

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
left, right, up, down, center  input  1 each  debounced button levels, 1 = pressed
enable  input  1  1 = cursor and fire active; 0 = frozen
cur_x  output  XW  cursor column
cur_y  output  YW  cursor row
fire_valid  output  1  fire request pending
fire_ready  input  1  game logic accepts the request
fire_x  output  XW  column latched for the fire request
fire_y  output  YW  row latched for the fire request
fire_dropped  output  1  one-cycle pulse: center press lost because a request was already pending

Behaviour:
- Reset, asynchronous on rst_n low:
  - cur_x = 0, cur_y = 0.
  - fire_valid = 0, fire_x = fire_y = 0, fire_dropped = 0.
  - FSM = IDLE; repeat counter = 0.
  - All sync and previous-level registers = 0, so a button held through reset yields exactly one press after release.
- Input path:
  - Each button passes through a 2-flop synchronizer (s1, s2), plus a prev register holding s2 from the prior cycle.
  - press = s2 & ~prev.
  - Latency: a level asserted before edge 1 reaches s2 at edge 2; cur_x/cur_y (or fire_valid) update at edge 3.
- Step rule, per axis:
  - dx = right_s2 - left_s2; dy = down_s2 - up_s2. Opposite buttons both held on one axis = no move on that axis.
  - Both axes may step in the same cycle (diagonal).
  - WRAP=0: clamp at the edges (left at x=0 stays 0; right at x=GRID_W-1 stays there). Same for y.
  - WRAP=1: 0 -> GRID_W-1 on left, GRID_W-1 -> 0 on right. Same for y.
- Repeat FSM, states IDLE, DELAY, REPEAT. "dir_held" = any of left/right/up/down s2 high; "dir_press" = any direction press.
  - IDLE: on dir_press, step once using the currently held levels, load counter = REPEAT_DELAY-1, go to DELAY.
  - DELAY: counter decrements each cycle. When the counter is 0 and dir_held, step using the held levels, load REPEAT_RATE-1, go to REPEAT.
  - REPEAT: on counter 0 and dir_held, step and reload REPEAT_RATE-1.
  - In DELAY or REPEAT, !dir_held -> IDLE next cycle, with no step.
  - In DELAY or REPEAT, a new dir_press steps immediately, reloads REPEAT_DELAY-1 and goes to DELAY. This has priority over counter expiry in the same cycle; only one step per cycle.
- Fire handshake:
  - center press with enable=1 and fire_valid=0: fire_valid <= 1; fire_x/fire_y <= cur_x/cur_y register values at that edge, i.e. pre-move if a step occurs in the same cycle.
  - fire_valid = 1 and fire_ready = 1 at a clk edge: fire_valid <= 0. fire_x/fire_y hold their last value.
  - center press while fire_valid = 1 (including the clearing cycle) is dropped, and fire_dropped pulses for 1 cycle.
  - center has no auto-repeat.
  - fire_x/fire_y are stable while fire_valid = 1.
- enable = 0:
  - No steps and no new fire requests.
  - FSM forced to IDLE; the cursor holds its value.
  - Synchronizers keep running, so presses are not deferred.
  - A pending fire_valid still completes its handshake.
- Mid-operation reset returns everything to the reset state immediately; no pending request survives.

Test Plan:
Bench uses REPEAT_DELAY=8 and REPEAT_RATE=4.
- Tap right for 3 cycles from reset -> cur_x = 1 at the 3rd edge after assertion; cur_y = 0; no further steps.
- Hold down for 30 cycles -> steps at press (+0), +8, +12, +16, +20, +24, +28 -> cur_y = 7; release -> FSM IDLE, no further steps.
- WRAP=0: at x=0 tap left -> cur_x stays 0. WRAP=1: at x=0 tap left -> cur_x = 9; at y=9 tap down -> cur_y = 0.
- Cursor at (3,4), tap center with fire_ready=0 -> fire_valid = 1, fire_x = 3, fire_y = 4. Move the cursor; fire_x/fire_y are unchanged. Second center tap -> fire_dropped pulses once. Raise fire_ready -> fire_valid = 0 next edge.
- Hold left and right together -> no x change. Hold up and right together -> diagonal steps: (0,5) -> (1,4).
- Hold up, then deassert enable mid-DELAY -> no steps and cursor frozen. Assert rst_n low mid-REPEAT with fire_valid = 1 -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/cursor_ctrl.sv
// Battleship targeting cursor: synchronizes the debounced buttons, steps the
// cursor with press + auto-repeat, and hands fire requests to game logic.
module cursor_ctrl #(
    parameter int GRID_W       = 10,
    parameter int GRID_H       = 10,
    parameter int XW           = 4,
    parameter int YW           = 4,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter bit WRAP         = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          left,
    input  logic          right,
    input  logic          up,
    input  logic          down,
    input  logic          center,
    input  logic          enable,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          fire_valid,
    input  logic          fire_ready,
    output logic [XW-1:0] fire_x,
    output logic [YW-1:0] fire_y,
    output logic          fire_dropped
);

    localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

    localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);
    localparam logic [CW-1:0] LD_DELAY = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] LD_RATE  = CW'(REPEAT_RATE - 1);

    // Button bit order: 0 left, 1 right, 2 up, 3 down, 4 center
    localparam int B_L = 0, B_R = 1, B_U = 2, B_D = 3, B_C = 4;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [4:0]    btn;
    logic [4:0]    s1_q, s2_q, prev_q;
    logic [4:0]    press;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] cur_x_q, cur_x_d, fire_x_q, fire_x_d;
    logic [YW-1:0] cur_y_q, cur_y_d, fire_y_q, fire_y_d;
    logic          fire_valid_q, fire_valid_d;
    logic          fire_dropped_q, fire_dropped_d;
    logic          dir_held, dir_press, step;

    assign btn       = {center, down, up, right, left};
    assign press     = s2_q & ~prev_q;
    assign dir_held  = |s2_q[B_D:B_L];
    assign dir_press = |press[B_D:B_L];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dir_press) begin
                        step    = 1'b1;
                        cnt_d   = LD_DELAY;
                        state_d = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    // A fresh press restarts the delay and wins over expiry
                    if (!dir_held) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (dir_press) begin
                        step    = 1'b1;
                        cnt_d   = LD_DELAY;
                        state_d = DELAY;
                    end else if (cnt_q == '0) begin
                        step    = 1'b1;
                        cnt_d   = LD_RATE;
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Opposite buttons on one axis cancel; each axis moves independently
    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (step) begin
            if (s2_q[B_R] && !s2_q[B_L])
                cur_x_d = (cur_x_q == X_MAX) ? (WRAP ? '0 : X_MAX) : cur_x_q + 1'b1;
            else if (s2_q[B_L] && !s2_q[B_R])
                cur_x_d = (cur_x_q == '0) ? (WRAP ? X_MAX : '0) : cur_x_q - 1'b1;
            if (s2_q[B_D] && !s2_q[B_U])
                cur_y_d = (cur_y_q == Y_MAX) ? (WRAP ? '0 : Y_MAX) : cur_y_q + 1'b1;
            else if (s2_q[B_U] && !s2_q[B_D])
                cur_y_d = (cur_y_q == '0) ? (WRAP ? Y_MAX : '0) : cur_y_q - 1'b1;
        end
    end

    // Fire coordinates come from the pre-step cursor registers
    always_comb begin
        fire_valid_d   = fire_valid_q;
        fire_x_d       = fire_x_q;
        fire_y_d       = fire_y_q;
        fire_dropped_d = 1'b0;
        if (fire_valid_q && fire_ready)
            fire_valid_d = 1'b0;
        if (press[B_C] && enable) begin
            if (fire_valid_q) begin
                fire_dropped_d = 1'b1;
            end else begin
                fire_valid_d = 1'b1;
                fire_x_d     = cur_x_q;
                fire_y_d     = cur_y_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q           <= '0;
            s2_q           <= '0;
            prev_q         <= '0;
            state_q        <= IDLE;
            cnt_q          <= '0;
            cur_x_q        <= '0;
            cur_y_q        <= '0;
            fire_valid_q   <= 1'b0;
            fire_x_q       <= '0;
            fire_y_q       <= '0;
            fire_dropped_q <= 1'b0;
        end else begin
            s1_q           <= btn;
            s2_q           <= s1_q;
            prev_q         <= s2_q;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cur_x_q        <= cur_x_d;
            cur_y_q        <= cur_y_d;
            fire_valid_q   <= fire_valid_d;
            fire_x_q       <= fire_x_d;
            fire_y_q       <= fire_y_d;
            fire_dropped_q <= fire_dropped_d;
        end
    end

    assign cur_x        = cur_x_q;
    assign cur_y        = cur_y_q;
    assign fire_valid   = fire_valid_q;
    assign fire_x       = fire_x_q;
    assign fire_y       = fire_y_q;
    assign fire_dropped = fire_dropped_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl: a clamping and a wrapping instance share
// the same stimulus; expected values are queued and popped at each check.
module tb_cursor_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0, center = 1'b0;
    logic       enable = 1'b1;
    logic       fire_ready = 1'b0;

    logic [3:0] x0, y0, fx0, fy0, x1, y1, fx1, fy1;
    logic       fv0, fd0, fv1, fd1;

    int checks = 0;
    int errors = 0;
    int sb[$];

    always #5 clk = ~clk;

    cursor_ctrl #(.GRID_W(10), .GRID_H(10), .XW(4), .YW(4),
                  .REPEAT_DELAY(8), .REPEAT_RATE(4), .WRAP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .left(left), .right(right), .up(up),
        .down(down), .center(center), .enable(enable), .cur_x(x0), .cur_y(y0),
        .fire_valid(fv0), .fire_ready(fire_ready), .fire_x(fx0), .fire_y(fy0),
        .fire_dropped(fd0));

    cursor_ctrl #(.GRID_W(10), .GRID_H(10), .XW(4), .YW(4),
                  .REPEAT_DELAY(8), .REPEAT_RATE(4), .WRAP(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .left(left), .right(right), .up(up),
        .down(down), .center(center), .enable(enable), .cur_x(x1), .cur_y(y1),
        .fire_valid(fv1), .fire_ready(fire_ready), .fire_x(fx1), .fire_y(fy1),
        .fire_dropped(fd1));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        sb.push_back(v);
    endtask

    task automatic chk(input string tag, input int obs);
        int exp_v;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty, observed %0d", tag, obs);
        end else begin
            exp_v = sb.pop_front();
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
            end
        end
    endtask

    task automatic do_reset();
        {left, right, up, down, center} = '0;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    // 1-cycle tap on a button; leaves time for the step and FSM return to IDLE
    task automatic tap(input int b);
        case (b)
            0: left = 1'b1;
            1: right = 1'b1;
            2: up = 1'b1;
            default: down = 1'b1;
        endcase
        tick(1);
        {left, right, up, down} = '0;
        tick(5);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tick(2);
        push(0); push(0); push(0); push(0); push(0); push(0);
        chk("rst_x", x0); chk("rst_y", y0); chk("rst_fv", fv0);
        chk("rst_fx", fx0); chk("rst_fd", fd0); chk("rst_fv1", fv1);
        rst_n = 1'b1;
        tick(1);

        // Tap right for 3 cycles: step lands on the 3rd edge
        right = 1'b1;
        push(0); tick(2); chk("tap_lat2", x0);
        push(1); tick(1); chk("tap_lat3", x0);
        right = 1'b0;
        push(1); push(0); tick(12); chk("tap_x_hold", x0); chk("tap_y", y0);

        // Hold down 30 cycles: steps at +0,+8,+12,...,+28
        down = 1'b1;
        push(1); tick(3);  chk("hold_first", y0);
        push(2); tick(8);  chk("hold_delay", y0);
        push(6); tick(19); chk("hold_mid", y0);
        down = 1'b0;
        push(7); tick(10); chk("hold_end", y0);
        push(7); tick(20); chk("hold_idle", y0);

        // Fire handshake at (3,4)
        do_reset();
        tap(1); tap(1); tap(1); tap(3); tap(3); tap(3); tap(3);
        push(3); push(4); chk("pos_x", x0); chk("pos_y", y0);
        center = 1'b1;
        tick(1); center = 1'b0; tick(2);
        push(1); push(3); push(4); push(0);
        chk("fire_v", fv0); chk("fire_x", fx0); chk("fire_y", fy0); chk("fire_nodrop", fd0);
        tap(1);
        push(4); push(3); chk("move_x", x0); chk("fire_x_stable", fx0);
        center = 1'b1;
        tick(1); center = 1'b0; tick(2);
        push(1); push(1); chk("drop_pulse", fd0); chk("drop_fv", fv0);
        push(0); tick(1); chk("drop_once", fd0);
        fire_ready = 1'b1;
        push(0); tick(1); chk("fire_clear", fv0);
        fire_ready = 1'b0;
        push(3); chk("fire_x_kept", fx0);

        // Opposite buttons cancel on an axis
        left = 1'b1; right = 1'b1;
        push(4); tick(15); chk("lr_cancel", x0);
        left = 1'b0; right = 1'b0;
        tick(4);

        // Diagonal from (0,5)
        do_reset();
        tap(3); tap(3); tap(3); tap(3); tap(3);
        up = 1'b1; right = 1'b1;
        push(1); push(4); tick(3); chk("diag_x", x0); chk("diag_y", y0);
        up = 1'b0; right = 1'b0;
        push(1); push(4); tick(5); chk("diag_x_hold", x0); chk("diag_y_hold", y0);

        // Edge clamp vs wrap
        do_reset();
        tap(0);
        push(0); push(9); chk("clamp_left", x0); chk("wrap_left", x1);
        tap(2);
        push(0); push(9); chk("clamp_up", y0); chk("wrap_up", y1);
        tap(3);
        push(0); push(1); chk("wrap_down", y1); chk("clamp_down", y0);

        // Enable dropped mid-DELAY freezes the cursor and blocks fire
        do_reset();
        tap(3); tap(3);
        up = 1'b1;
        push(1); tick(3); chk("en_first", y0);
        tick(3);
        enable = 1'b0;
        push(1); tick(12); chk("en_frozen", y0);
        center = 1'b1; tick(1); center = 1'b0;
        push(0); tick(5); chk("en_nofire", fv0);
        up = 1'b0; enable = 1'b1;
        tick(5);

        // Async reset mid-REPEAT with a pending request
        do_reset();
        down = 1'b1; center = 1'b1;
        tick(1); center = 1'b0; tick(2);
        push(1); push(1); push(0); chk("pre_y", y0); chk("pre_fv", fv0); chk("pre_fy", fy0);
        push(2); tick(10); chk("rep_y", y0);
        rst_n = 1'b0;
        #2;
        push(0); push(0); push(0); push(0);
        chk("arst_y", y0); chk("arst_fv", fv0); chk("arst_x", x0); chk("arst_fv1", fv1);
        down = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
